// File: rtl/spi_reg_bridge_mc_if.sv
// SPI pins plus the TinyQV-style peripheral bus that the bridge drives.
interface spi_reg_bridge_mc_if #(
  parameter int ADDR_W  = 6,
  parameter int REG_W   = 32,
  parameter int N_SLOTS = 4
);
  logic                     spi_cs_n;
  logic                     spi_clk;
  logic                     spi_mosi;
  logic                     spi_miso;
  logic [N_SLOTS-1:0]       slot_sel;
  logic [ADDR_W-1:0]        address;
  logic [REG_W-1:0]         data_in;
  logic [1:0]               data_write_n;
  logic [1:0]               data_read_n;
  logic [N_SLOTS*REG_W-1:0] data_out;
  logic [N_SLOTS-1:0]       data_ready;
  logic                     busy;
  logic                     err;

  modport slave (
    input  spi_cs_n, spi_clk, spi_mosi, data_out, data_ready,
    output spi_miso, slot_sel, address, data_in, data_write_n, data_read_n, busy, err
  );

  modport master (
    output spi_cs_n, spi_clk, spi_mosi, data_out, data_ready,
    input  spi_miso, slot_sel, address, data_in, data_write_n, data_read_n, busy, err
  );
endinterface

// File: rtl/spi_reg_bridge_mc.sv
// SPI-slave command decoder driving a multi-slot register bus: slot select,
// sized writes, reads with a ready timeout, and a sticky error flag.
module spi_reg_bridge_mc #(
  parameter int ADDR_W  = 6,
  parameter int REG_W   = 32,
  parameter int N_SLOTS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_reg_bridge_mc_if.slave bus
);
  localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int HDR_LEN = 3 + SLOT_W + ADDR_W;
  localparam int TCNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [N_SLOTS-1:0] SEL_ONE = N_SLOTS'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WDATA, S_RWAIT, S_RDATA, S_DONE, S_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_cs_q, r_sclk_q;
  logic [HDR_LEN-2:0]  r_hdr;
  logic [5:0]          r_bcnt;
  logic [1:0]          r_txn;
  logic [SLOT_W-1:0]   r_slot;
  logic [REG_W-2:0]    r_wdat;
  logic [REG_W-1:0]    r_rdat;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_miso, r_busy, r_err;
  logic [N_SLOTS-1:0]  r_slot_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic [REG_W-1:0]    r_data_in;
  logic [1:0]          r_wr_n, r_rd_n;

  logic                w_rise, w_fall, w_cs_fall;
  logic [HDR_LEN-1:0]  w_hdr;
  logic                w_hdr_rw, w_slot_ok, w_ready, w_wr_clr;
  logic [1:0]          w_hdr_txn;
  logic [SLOT_W-1:0]   w_hdr_slot;
  logic [ADDR_W-1:0]   w_hdr_addr;
  logic [REG_W-1:0]    w_wdat, w_sel_data, w_rd_latch;
  logic [5:0]          w_len;

  assign w_rise     = ~r_sclk_q &  bus.spi_clk & ~bus.spi_cs_n;
  assign w_fall     =  r_sclk_q & ~bus.spi_clk & ~bus.spi_cs_n;
  assign w_cs_fall  =  r_cs_q & ~bus.spi_cs_n;
  assign w_hdr      = {r_hdr, bus.spi_mosi};
  assign w_hdr_rw   = w_hdr[HDR_LEN-1];
  assign w_hdr_txn  = w_hdr[HDR_LEN-2 -: 2];
  assign w_hdr_slot = w_hdr[ADDR_W +: SLOT_W];
  assign w_hdr_addr = w_hdr[ADDR_W-1:0];
  assign w_slot_ok  = int'(w_hdr_slot) < N_SLOTS;
  assign w_wdat     = {r_wdat, bus.spi_mosi};
  assign w_sel_data = bus.data_out[int'(r_slot)*REG_W +: REG_W];
  assign w_ready    = bus.data_ready[r_slot];
  assign w_wr_clr   = (r_slot == '0) && (&r_addr);

  always_comb begin
    w_len = 6'd32;
    case (r_txn)
      2'b00:   w_len = 6'd8;
      2'b01:   w_len = 6'd16;
      default: w_len = 6'd32;
    endcase
  end

  // Read data is held MSB-aligned so the shifter always emits from the top bit.
  always_comb begin
    w_rd_latch = w_sel_data;
    case (r_txn)
      2'b00:   w_rd_latch = {w_sel_data[7:0],  {(REG_W-8){1'b0}}};
      2'b01:   w_rd_latch = {w_sel_data[15:0], {(REG_W-16){1'b0}}};
      default: w_rd_latch = w_sel_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cs_q     <= 1'b1;
      r_sclk_q   <= 1'b0;
      r_hdr      <= '0;
      r_bcnt     <= '0;
      r_txn      <= '0;
      r_slot     <= '0;
      r_wdat     <= '0;
      r_rdat     <= '0;
      r_tcnt     <= '0;
      r_miso     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_slot_sel <= '0;
      r_addr     <= '0;
      r_data_in  <= '0;
      r_wr_n     <= 2'b11;
      r_rd_n     <= 2'b11;
    end else begin
      r_cs_q   <= bus.spi_cs_n;
      r_sclk_q <= bus.spi_clk;
      if (r_state != S_IDLE && bus.spi_cs_n) begin
        // Frame ended or aborted: drop any pending strobe or read.
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_miso     <= 1'b0;
        r_wr_n     <= 2'b11;
        r_rd_n     <= 2'b11;
        r_slot_sel <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) begin
            r_state <= S_HDR;
            r_busy  <= 1'b1;
            r_bcnt  <= '0;
            r_hdr   <= '0;
          end
          S_HDR: if (w_rise) begin
            r_hdr  <= w_hdr[HDR_LEN-2:0];
            r_bcnt <= r_bcnt + 6'd1;
            if (r_bcnt == 6'(HDR_LEN-1)) begin
              r_bcnt <= '0;
              r_txn  <= w_hdr_txn;
              r_slot <= w_hdr_slot;
              r_addr <= w_hdr_addr;
              r_wdat <= '0;
              r_tcnt <= '0;
              if (w_hdr_txn == 2'b11 || !w_slot_ok) begin
                r_err   <= 1'b1;
                r_state <= S_DRAIN;
              end else if (w_hdr_rw) begin
                r_state <= S_WDATA;
              end else begin
                r_state    <= S_RWAIT;
                r_rd_n     <= w_hdr_txn;
                r_slot_sel <= SEL_ONE << w_hdr_slot;
              end
            end
          end
          S_WDATA: if (w_rise) begin
            r_wdat <= w_wdat[REG_W-2:0];
            r_bcnt <= r_bcnt + 6'd1;
            if (r_bcnt == w_len - 6'd1) begin
              r_data_in  <= w_wdat;
              r_wr_n     <= r_txn;
              r_slot_sel <= SEL_ONE << r_slot;
              r_state    <= S_DONE;
              if (w_wr_clr) r_err <= 1'b0;
            end
          end
          S_RWAIT: begin
            if (w_rise) r_bcnt <= r_bcnt + 6'd1;
            // Master reached the data phase before the peripheral answered.
            if (w_fall && r_bcnt >= 6'd8) begin
              r_err      <= 1'b1;
              r_rdat     <= '1;
              r_miso     <= 1'b1;
              r_rd_n     <= 2'b11;
              r_slot_sel <= '0;
              r_state    <= S_RDATA;
            end else if (w_ready) begin
              r_rdat     <= w_rd_latch;
              r_rd_n     <= 2'b11;
              r_slot_sel <= '0;
              r_state    <= S_RDATA;
            end else if (r_tcnt == TCNT_W'(TIMEOUT-1)) begin
              r_rdat     <= '1;
              r_err      <= 1'b1;
              r_rd_n     <= 2'b11;
              r_slot_sel <= '0;
              r_state    <= S_RDATA;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_RDATA: begin
            if (w_rise) begin
              if (r_bcnt == w_len + 6'd7) begin
                r_state <= S_DONE;
                r_miso  <= 1'b0;
              end else begin
                r_bcnt <= r_bcnt + 6'd1;
              end
            end
            if (w_fall && r_bcnt >= 6'd8) begin
              r_miso <= r_rdat[REG_W-1];
              r_rdat <= {r_rdat[REG_W-2:0], 1'b0};
            end
          end
          S_DONE: begin
            r_wr_n     <= 2'b11;
            r_slot_sel <= '0;
            r_miso     <= 1'b0;
          end
          S_DRAIN: r_miso <= 1'b0;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.spi_miso     = r_miso;
  assign bus.slot_sel     = r_slot_sel;
  assign bus.address      = r_addr;
  assign bus.data_in      = r_data_in;
  assign bus.data_write_n = r_wr_n;
  assign bus.data_read_n  = r_rd_n;
  assign bus.busy         = r_busy;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_spi_reg_bridge_mc.sv
// Directed bench: bit-banged SPI frames, simple peripheral model, scoreboarded strobes/read data.
module tb_spi_reg_bridge_mc;
  localparam int ADDR_W = 6, REG_W = 32, N_SLOTS = 4, TIMEOUT = 255, HP = 20;

  typedef struct packed {
    logic [N_SLOTS-1:0] sel;
    logic [ADDR_W-1:0]  addr;
    logic [REG_W-1:0]   data;
    logic [1:0]         wrn;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_reg_bridge_mc_if #(.ADDR_W(ADDR_W), .REG_W(REG_W), .N_SLOTS(N_SLOTS)) bif ();
  spi_reg_bridge_mc #(.ADDR_W(ADDR_W), .REG_W(REG_W), .N_SLOTS(N_SLOTS), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  wr_t         wq[$];
  logic [31:0] rq[$];
  wr_t         wr_obs[$];
  int          wr_rd = 0;
  int          rd_delay = 0, rd_cnt = 0, rd_cycles = 0, rd_mis = 0;
  logic [N_SLOTS-1:0] exp_rd_sel = '0;
  logic [1:0]         exp_rd_txn = 2'b11;

  // Peripheral model and bus monitor.
  always @(negedge clk) begin
    if (bif.data_write_n !== 2'b11)
      wr_obs.push_back({bif.slot_sel, bif.address, bif.data_in, bif.data_write_n});
    if (bif.data_read_n !== 2'b11) begin
      rd_cnt++;
      rd_cycles++;
      if ({bif.slot_sel, bif.data_read_n} !== {exp_rd_sel, exp_rd_txn}) rd_mis++;
    end else begin
      rd_cnt = 0;
    end
    bif.data_ready = (rd_delay != 0 && rd_cnt >= rd_delay) ? bif.slot_sel : '0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int len_of(input logic [1:0] t);
    return (t == 2'b00) ? 8 : (t == 2'b01) ? 16 : 32;
  endfunction

  function automatic logic [31:0] mask_of(input int len);
    return (len >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << len) - 64'd1);
  endfunction

  task automatic xfer(input logic [63:0] tx, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bif.spi_mosi = tx[i];
      wait_cyc(HP);
      bif.spi_clk = 1'b1;
      rx = {rx[62:0], bif.spi_miso};
      wait_cyc(HP);
      bif.spi_clk = 1'b0;
    end
    bif.spi_mosi = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    wait_cyc(4);
    bif.spi_cs_n = 1'b1;
    wait_cyc(6);
    check({tag, "_busy_lo"}, 64'(bif.busy), 64'd0);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check({tag, "_wr_cnt"}, 64'(wr_obs.size() - wr_rd), 64'(n_exp));
    while (wq.size() != 0 && wr_rd < wr_obs.size()) begin
      check({tag, "_wr"}, 64'(wr_obs[wr_rd]), 64'(wq.pop_front()));
      wr_rd++;
    end
    wr_rd = wr_obs.size();
    wq.delete();
  endtask

  task automatic do_write(input logic [1:0] s, input logic [5:0] a, input logic [1:0] t,
                          input logic [31:0] d, input string tag);
    int len = len_of(t);
    logic [63:0] tx, rx;
    wr_t e;
    e.sel  = 4'b0001 << s;
    e.addr = a;
    e.data = d & mask_of(len);
    e.wrn  = t;
    wq.push_back(e);
    tx = (64'({1'b1, t, s, a}) << len) | 64'(d & mask_of(len));
    bif.spi_cs_n = 1'b0;
    wait_cyc(4);
    check({tag, "_busy_hi"}, 64'(bif.busy), 64'd1);
    xfer(tx, 11 + len, rx);
    end_frame(tag);
    check_writes(tag, 1);
  endtask

  task automatic do_read(input logic [1:0] s, input logic [5:0] a, input logic [1:0] t,
                         input int delay, input logic [31:0] exp_d, input int exp_cyc,
                         input string tag);
    int len = len_of(t);
    int c0 = rd_cycles;
    logic [63:0] tx, rx;
    rd_delay   = delay;
    exp_rd_sel = 4'b0001 << s;
    exp_rd_txn = t;
    rq.push_back(exp_d & mask_of(len));
    tx = 64'({1'b0, t, s, a}) << (8 + len);
    bif.spi_cs_n = 1'b0;
    wait_cyc(4);
    xfer(tx, 19 + len, rx);
    end_frame(tag);
    check({tag, "_miso"}, 64'(rx[31:0] & mask_of(len)), 64'(rq.pop_front()));
    check({tag, "_rd_cycles"}, 64'(rd_cycles - c0), 64'(exp_cyc));
    check_writes(tag, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [63:0] rx;
    int c0;
    bif.spi_cs_n = 1'b1;
    bif.spi_clk  = 1'b0;
    bif.spi_mosi = 1'b0;
    bif.data_out = {32'h55AA_33CC, 32'h0BAD_F00D, 32'h1234_5678, 32'hA5C3_0F96};
    wait_cyc(3);
    check("rst_miso", 64'(bif.spi_miso), 64'd0);
    check("rst_sel",  64'(bif.slot_sel), 64'd0);
    check("rst_addr", 64'(bif.address), 64'd0);
    check("rst_din",  64'(bif.data_in), 64'd0);
    check("rst_wrn",  64'(bif.data_write_n), 64'd3);
    check("rst_rdn",  64'(bif.data_read_n), 64'd3);
    check("rst_busy", 64'(bif.busy), 64'd0);
    check("rst_err",  64'(bif.err), 64'd0);
    rst_n = 1'b1;
    wait_cyc(3);

    do_write(2'd2, 6'h05, 2'b10, 32'hDEAD_BEEF, "w_word");
    check("w_word_err", 64'(bif.err), 64'd0);

    do_read(2'd1, 6'h03, 2'b00, 3, 32'h0000_0078, 3, "r_byte");
    check("r_byte_err", 64'(bif.err), 64'd0);

    do_read(2'd3, 6'h10, 2'b01, 0, 32'h0000_FFFF, TIMEOUT, "r_tmo");
    check("r_tmo_err", 64'(bif.err), 64'd1);
    do_write(2'd0, 6'h3F, 2'b00, 32'h0000_0012, "w_clr");
    check("w_clr_err", 64'(bif.err), 64'd0);

    // Invalid width: no strobes, MISO stays low, error latched.
    c0 = rd_cycles;
    rq.push_back(32'd0);
    bif.spi_cs_n = 1'b0;
    wait_cyc(4);
    xfer(64'({1'b1, 2'b11, 2'd0, 6'h2A}) << 8 | 64'hFF, 19, rx);
    check("bad_txn_err", 64'(bif.err), 64'd1);
    end_frame("bad_txn");
    check("bad_txn_miso", 64'(rx[31:0]), 64'(rq.pop_front()));
    check("bad_txn_rd", 64'(rd_cycles - c0), 64'd0);
    check_writes("bad_txn", 0);

    // Abort a word write after 20 of 32 data bits.
    bif.spi_cs_n = 1'b0;
    wait_cyc(4);
    xfer(64'({1'b1, 2'b10, 2'd1, 6'h0A}) << 20 | 64'hABCDE, 31, rx);
    end_frame("abort");
    check_writes("abort", 0);
    do_write(2'd1, 6'h0A, 2'b10, 32'hCAFE_F00D, "w_after");
    check("w_after_err", 64'(bif.err), 64'd1);
    do_write(2'd0, 6'h3F, 2'b01, 32'h1234_BEEF, "w_half_clr");
    check("w_half_clr_err", 64'(bif.err), 64'd0);

    // Asynchronous reset in the middle of a read wait.
    rd_delay   = 0;
    exp_rd_sel = 4'b0100;
    exp_rd_txn = 2'b10;
    bif.spi_cs_n = 1'b0;
    wait_cyc(4);
    xfer(64'({1'b0, 2'b10, 2'd2, 6'h01}), 11, rx);
    wait_cyc(10);
    check("mid_rdn", 64'(bif.data_read_n), 64'd2);
    check("mid_sel", 64'(bif.slot_sel), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdn",  64'(bif.data_read_n), 64'd3);
    check("arst_sel",  64'(bif.slot_sel), 64'd0);
    check("arst_busy", 64'(bif.busy), 64'd0);
    check("arst_addr", 64'(bif.address), 64'd0);
    check("arst_din",  64'(bif.data_in), 64'd0);
    check("arst_wrn",  64'(bif.data_write_n), 64'd3);
    bif.spi_cs_n = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);

    do_read(2'd0, 6'h01, 2'b10, 1, 32'hA5C3_0F96, 1, "r_word");
    check("r_word_err", 64'(bif.err), 64'd0);
    check("rd_req_mismatches", 64'(rd_mis), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
